// File: rtl/shift_pkg.sv
// Shared constants and clear-FSM state type for the shift_buf_mc delay-line block.
package shift_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int DEPTH_DEF    = 32;
  localparam int CHANNELS_DEF = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/shift_ram.sv
// One channel of tap storage: DEPTH x DATA_W, one write port, registered read port(s).
// The array itself has no reset; the parent zeroes it row by row after reset.
// Define SHIFT_BUF_SYM_EN to add the second (mirrored-tap) read port.
module shift_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
`ifdef SHIFT_BUF_SYM_EN
  ,
  input  logic [AW-1:0]     i_raddr2,
  output logic [DATA_W-1:0] o_rdata2
`endif
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // storage write, no reset on the array
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // registered read; holds its value when not enabled, so pre-write data is returned on collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

`ifdef SHIFT_BUF_SYM_EN
  // mirrored-tap read port, same timing as the main port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rdata2 <= '0;
    end else if (i_re) begin
      o_rdata2 <= r_mem[i_raddr2];
    end
  end
`endif

endmodule

// File: rtl/shift_buf_mc.sv
// Multi-channel tapped delay line built from per-channel circular buffers.
// Reset and clr run a DEPTH-cycle row-by-row zeroing sweep; the block is busy meanwhile.
// Define SHIFT_BUF_SYM_EN to add out_sym (tap DEPTH-1-rd_tap) for folded symmetric FIR.
module shift_buf_mc
  import shift_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int CHANNELS = CHANNELS_DEF,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW-1:0]       in_ch,
  input  logic [DATA_W-1:0]   probka_in,
  input  logic                rd_en,
  input  logic [CW-1:0]       rd_ch,
  input  logic [AW-1:0]       rd_tap,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   out,
  output logic [CHANNELS-1:0] full
`ifdef SHIFT_BUF_SYM_EN
  ,
  output logic [DATA_W-1:0]   out_sym
`endif
);

  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
  localparam logic [AW:0]   DEPTH_M1 = (AW+1)'(DEPTH - 1);

  clr_state_t        r_state;
  logic [AW-1:0]     r_cnt;
  logic [AW-1:0]     r_wp [CHANNELS];
  logic [CHANNELS-1:0] r_full;
  logic              r_rd_valid;
  logic              r_oob;
  logic [CW-1:0]     r_rch;

  logic              w_idle, w_clearing, w_wr, w_rd, w_rd_oob;
  logic              w_in_ch_ok, w_rd_ch_ok;
  logic [CW-1:0]     w_wch, w_rch;
  logic [AW-1:0]     w_tap, w_wp_rd, w_raddr;
  logic [AW:0]       w_sum;
  logic [DATA_W-1:0] w_rdata [CHANNELS];

  assign w_idle     = (r_state == ST_IDLE);
  assign w_clearing = (r_state == ST_CLEAR);
  assign busy       = w_clearing;
  assign in_ready   = w_idle;
  assign rd_valid   = r_rd_valid;
  assign full       = r_full;

  // clr in IDLE wins over a same-cycle write or read
  assign w_in_ch_ok = (32'(in_ch) < CHANNELS);
  assign w_rd_ch_ok = (32'(rd_ch) < CHANNELS);
  assign w_wch      = w_in_ch_ok ? in_ch : '0;
  assign w_rch      = w_rd_ch_ok ? rd_ch : '0;
  assign w_wr       = in_valid & w_idle & ~clr & w_in_ch_ok;
  assign w_rd       = rd_en & w_idle & ~clr;
  assign w_rd_oob   = (32'(rd_tap) >= DEPTH) | ~w_rd_ch_ok;
  assign w_tap      = w_rd_oob ? '0 : rd_tap;

  // tap k lives at (wp-1-k) mod DEPTH; computed one bit wider so it never goes negative
  assign w_wp_rd = r_wp[w_rch];
  assign w_sum   = {1'b0, w_wp_rd} + DEPTH_M1 - {1'b0, w_tap};
  assign w_raddr = AW'((w_sum >= DEPTH_X) ? (w_sum - DEPTH_X) : w_sum);

`ifdef SHIFT_BUF_SYM_EN
  logic [AW:0]       w_sum2;
  logic [AW-1:0]     w_raddr2;
  logic [DATA_W-1:0] w_rdata2 [CHANNELS];
  // tap DEPTH-1-k lives at (wp+k) mod DEPTH
  assign w_sum2   = {1'b0, w_wp_rd} + {1'b0, w_tap};
  assign w_raddr2 = AW'((w_sum2 >= DEPTH_X) ? (w_sum2 - DEPTH_X) : w_sum2);
  assign out_sym  = r_oob ? '0 : w_rdata2[r_rch];
`endif

  assign out = r_oob ? '0 : w_rdata[r_rch];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic              w_we;
    logic              w_re;
    logic [AW-1:0]     w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_we    = w_clearing | (w_wr & (in_ch == CW'(c)));
    assign w_re    = w_rd & ~w_rd_oob & (rd_ch == CW'(c));
    assign w_waddr = w_clearing ? r_cnt : r_wp[c];
    assign w_wdata = w_clearing ? '0 : probka_in;

    shift_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
    ) u_ram (
      .clk      (clk),
      .rst      (rst),
      .i_we     (w_we),
      .i_waddr  (w_waddr),
      .i_wdata  (w_wdata),
      .i_re     (w_re),
      .i_raddr  (w_raddr),
      .o_rdata  (w_rdata[c])
`ifdef SHIFT_BUF_SYM_EN
      ,
      .i_raddr2 (w_raddr2),
      .o_rdata2 (w_rdata2[c])
`endif
    );
  end

  // clear sequencer: sweep rows 0..DEPTH-1, clr restarts the sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr) begin
            r_cnt <= '0;
          end else if (r_cnt == LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // write pointers and full flags; full sets on the wrap from DEPTH-1 (the DEPTH-th write)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) r_wp[c] <= '0;
      r_full <= '0;
    end else if (w_clearing || clr) begin
      for (int c = 0; c < CHANNELS; c++) r_wp[c] <= '0;
      r_full <= '0;
    end else if (w_wr) begin
      if (r_wp[w_wch] == LAST) begin
        r_wp[w_wch]   <= '0;
        r_full[w_wch] <= 1'b1;
      end else begin
        r_wp[w_wch] <= r_wp[w_wch] + AW'(1);
      end
    end
  end

  // read-side registers; channel select and out-of-range flag hold between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_oob      <= 1'b0;
      r_rch      <= '0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_oob <= w_rd_oob;
        r_rch <= w_rch;
      end
    end
  end

endmodule

// File: tb/tb_shift_buf_mc.sv
// Directed bench for shift_buf_mc: a DEPTH=32/CHANNELS=2 instance plus a DEPTH=5/CHANNELS=1
// instance sharing clock, reset, clr and write data. Define SHIFT_BUF_SYM_EN to cover out_sym.
`timescale 1ns/1ps
module tb_shift_buf_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [0:0]  in_ch = '0;
  logic [15:0] probka_in = '0;
  logic        rd_en = 1'b0;
  logic [0:0]  rd_ch = '0;
  logic [4:0]  rd_tap = '0;
  logic        busy, in_ready, rd_valid;
  logic [15:0] out;
  logic [1:0]  full;

  logic [0:0]  in_ch5 = '0;
  logic [0:0]  rd_ch5 = '0;
  logic        rd_en5 = 1'b0;
  logic [2:0]  rd_tap5 = '0;
  logic        busy5, in_ready5, rd_valid5;
  logic [15:0] out5;
  logic [0:0]  full5;
`ifdef SHIFT_BUF_SYM_EN
  logic [15:0] out_sym, out_sym5;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_buf_mc #(.DATA_W(16), .DEPTH(32), .CHANNELS(2)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .probka_in(probka_in),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_tap(rd_tap), .rd_valid(rd_valid), .out(out),
    .full(full)
`ifdef SHIFT_BUF_SYM_EN
    , .out_sym(out_sym)
`endif
  );

  shift_buf_mc #(.DATA_W(16), .DEPTH(5), .CHANNELS(1)) u_dut5 (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy5),
    .in_valid(in_valid), .in_ready(in_ready5), .in_ch(in_ch5), .probka_in(probka_in),
    .rd_en(rd_en5), .rd_ch(rd_ch5), .rd_tap(rd_tap5), .rd_valid(rd_valid5), .out(out5),
    .full(full5)
`ifdef SHIFT_BUF_SYM_EN
    , .out_sym(out_sym5)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // one clock of stimulus on the main instance; entered and left on a falling edge
  task automatic cyc(input logic wv, input logic [0:0] wch, input logic [15:0] wd,
                     input logic re, input logic [0:0] rch, input logic [4:0] tap);
    in_valid = wv; in_ch = wch; probka_in = wd;
    rd_en = re; rd_ch = rch; rd_tap = tap;
    @(negedge clk);
    in_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic rd(input logic [0:0] ch, input logic [4:0] tap, input string tag,
                    input logic [15:0] exp);
    cyc(1'b0, 1'b0, 16'd0, 1'b1, ch, tap);
    chk({tag, "_vld"}, rd_valid, 1);
    chk(tag, out, exp);
  endtask

  task automatic rd5(input logic [2:0] tap, input string tag, input logic [15:0] exp);
    rd_en5 = 1'b1; rd_tap5 = tap;
    @(negedge clk);
    rd_en5 = 1'b0;
    chk({tag, "_vld"}, rd_valid5, 1);
    chk(tag, out5, exp);
  endtask

  // counts falling edges until both instances leave the clear sweep
  task automatic wait_idle(output int n, output int n5);
    n = 0; n5 = 0;
    while ((busy || busy5) && n < 200) begin
      @(negedge clk);
      n++;
      if (!busy5 && n5 == 0) n5 = n;
    end
  endtask

  initial begin
    int n, n5, bad_rdy, bad_rdv;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_full", full, 0);

    rst = 1'b0;
    wait_idle(n, n5);
    chk("rst_clear_len", n, 32);
    chk("rst_clear_len5", n5, 5);
    chk("in_ready_up", in_ready, 1);

    for (int k = 0; k < 32; k++) rd(1'b0, 5'(k), $sformatf("init_tap%0d", k), 16'd0);
    @(negedge clk);
    chk("idle_rd_valid", rd_valid, 0);

    cyc(1'b1, 1'b0, 16'd5, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 1'b0, 16'd10, 1'b0, 1'b0, 5'd0);
    rd(1'b0, 5'd0, "two_tap0", 16'd10);
    rd(1'b0, 5'd1, "two_tap1", 16'd5);
    rd(1'b0, 5'd2, "two_tap2", 16'd0);
    rd(1'b1, 5'd0, "two_ch1_tap0", 16'd0);
    chk("two_full", full, 0);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wait_idle(n, n5);
    chk("clr_len", n, 32);
    chk("clr_len5", n5, 5);

    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0, 16'(i * 2), 1'b0, 1'b0, 5'd0);
      chk($sformatf("full_w%0d", i + 1), full, {1'b0, (i >= 31)});
      chk($sformatf("full5_w%0d", i + 1), full5, (i >= 4));
    end
    rd(1'b0, 5'd31, "wrap_tap31", 16'd16);
    rd(1'b0, 5'd1, "wrap_tap1", 16'd76);
    rd(1'b0, 5'd0, "wrap_tap0", 16'd78);
    @(negedge clk);
    chk("hold_rd_valid", rd_valid, 0);
    chk("hold_out", out, 78);
    rd5(3'd0, "d5_tap0", 16'd78);
    rd5(3'd4, "d5_tap4", 16'd70);
    rd5(3'd5, "d5_oob5", 16'd0);
    rd5(3'd2, "d5_tap2", 16'd74);
    rd5(3'd7, "d5_oob7", 16'd0);

    cyc(1'b1, 1'b0, 16'd7, 1'b1, 1'b0, 5'd0);
    chk("coll_vld", rd_valid, 1);
    chk("coll_out", out, 78);
    rd(1'b0, 5'd0, "after_coll_tap0", 16'd7);
    rd(1'b0, 5'd1, "after_coll_tap1", 16'd78);
    chk("full_kept", full, 2'b01);

    clr = 1'b1; in_valid = 1'b1; in_ch = 1'b0; probka_in = 16'd99;
    rd_en = 1'b1; rd_ch = 1'b0; rd_tap = 5'd0;
    @(negedge clk);
    n = 0; bad_rdy = 0; bad_rdv = 0;
    while (busy && n < 200) begin
      n++;
      if (in_ready) bad_rdy++;
      if (rd_valid) bad_rdv++;
      clr = (n == 10);
      @(negedge clk);
    end
    clr = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
    chk("reclr_len", n, 42);
    chk("reclr_in_ready", bad_rdy, 0);
    chk("reclr_rd_valid", bad_rdv, 0);
    chk("reclr_full", full, 0);
    rd(1'b0, 5'd0, "reclr_tap0", 16'd0);
    rd(1'b0, 5'd1, "reclr_tap1", 16'd0);
    rd(1'b0, 5'd31, "reclr_tap31", 16'd0);
    rd(1'b1, 5'd0, "reclr_ch1_tap0", 16'd0);

`ifdef SHIFT_BUF_SYM_EN
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 16'(i), 1'b0, 1'b0, 5'd0);
    rd(1'b1, 5'd3, "sym_tap3", 16'd28);
    chk("sym_out_sym3", out_sym, 3);
    rd(1'b1, 5'd0, "sym_tap0", 16'd31);
    chk("sym_out_sym0", out_sym, 0);
    rd(1'b0, 5'd0, "sym_ch0_tap0", 16'd0);
    chk("sym_full", full, 2'b10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_buf_mc.md
SHIFT_BUF_MC -- requirements
Module: shift_buf_mc

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter DATA_W, 16, sample width in bits; SHALL be 2 or more.
REQ-003 Parameter DEPTH, 32, taps per channel; SHALL be 2 or more, and need not be a power of two.
REQ-004 Parameter CHANNELS, 2, number of independent delay lines; SHALL be 1 or more.
REQ-005 Port clk  in  1  rising-edge clock.
REQ-006 Port rst  in  1  asynchronous active-high reset.
REQ-007 Port clr  in  1  single-cycle request to zero all channels.
REQ-008 Port busy  out  1  clear sequence in progress.
REQ-009 Port in_valid  in  1  sample write request.
REQ-010 Port in_ready  out  1  write accepted when in_valid and in_ready are both high; equals !busy.
REQ-011 Port in_ch  in  clog2(CHANNELS) (min 1)  target channel of the write.
REQ-012 Port probka_in  in  DATA_W  new sample.
REQ-013 Port rd_en  in  1  tap read request.
REQ-014 Port rd_ch  in  clog2(CHANNELS) (min 1)  channel to read.
REQ-015 Port rd_tap  in  clog2(DEPTH)  tap index; 0 is the newest sample.
REQ-016 Port rd_valid  out  1  out is valid this cycle.
REQ-017 Port out  out  DATA_W  tap data.
REQ-018 Port full  out  CHANNELS  bit c is set once channel c holds DEPTH real samples.

Function
REQ-019 Each channel SHALL be a circular buffer with its own write pointer wp[c], so accepting a sample moves no data.
REQ-020 An accepted write SHALL store probka_in at wp[in_ch] and advance wp[in_ch], wrapping from DEPTH-1 to 0.
REQ-021 Tap k of channel c SHALL be the sample accepted k writes before the newest one, read at address (wp[c]-1-k) mod DEPTH.
REQ-022 Any tap not yet written since the last clear SHALL read 0.
REQ-023 A read SHALL have latency 1: rd_en at cycle t gives rd_valid=1 and out at t+1; otherwise rd_valid=0 and out holds its last value.
REQ-024 When a write and a read hit the same channel in the same cycle, the read SHALL return pre-write contents and pointer.
REQ-025 A rd_tap value of DEPTH or more SHALL return 0 with rd_valid=1.
REQ-026 The clear state machine SHALL have states IDLE and CLEAR.
REQ-027 In CLEAR, one row per cycle SHALL be zeroed across all channels, using a counter that runs 0..DEPTH-1; the return to IDLE SHALL happen after row DEPTH-1.
REQ-028 While busy, writes SHALL be refused, rd_en SHALL be ignored (rd_valid=0), and wp and full SHALL be held at 0.
REQ-029 A clr asserted during CLEAR SHALL restart the counter at 0.
REQ-030 A clr asserted in IDLE SHALL take priority over a write or read in the same cycle.
REQ-031 Bit full[c] SHALL set on the DEPTH-th accepted write since clear, stay set, and clear only on clear or reset.

Reset
REQ-032 While rst is high: wp=0, full=0, rd_valid=0, out=0, counter=0, state=CLEAR, busy=1, in_ready=0.
REQ-033 After rst falls, the block SHALL run a full DEPTH-cycle clear before in_ready rises, so the storage array needs no reset.

Configuration
REQ-034 With SHIFT_BUF_SYM_EN defined, the block SHALL add output out_sym [DATA_W], which returns tap DEPTH-1-rd_tap with the same latency and validity as out; this serves folded symmetric FIR.
REQ-035 Without SHIFT_BUF_SYM_EN, out_sym and its second read port SHALL be absent.

Structure
REQ-036 Package shift_pkg SHALL hold the default DATA_W/DEPTH/CHANNELS constants and the clear-FSM state enum.
REQ-037 Sub-module shift_ram SHALL be instanced once per channel: DEPTH x DATA_W, one write port, and one registered read port (two read ports under SHIFT_BUF_SYM_EN).

Verification (DATA_W=16, DEPTH=32, CHANNELS=2 unless stated)
REQ-038 Reset, then wait for busy to fall (32 cycles after rst release); reading ch0 taps 0..31 -> all 0, with rd_valid one cycle after each rd_en.
REQ-039 Write 5 then 10 to ch0 -> ch0 tap0=10, tap1=5, tap2=0; ch1 tap0=0; full=2'b00.
REQ-040 Write i*2 for i=0..39 to ch0 -> full[0] rises on the 32nd write; tap0=78, tap31=16; repeat with DEPTH=5 to check wrap.
REQ-041 Write 7 and read ch0 tap0 in the same cycle -> out returns the previous newest sample; the next read returns 7.
REQ-042 Assert clr mid-stream with in_valid held high -> busy for 32 cycles, no writes accepted, all taps 0, full cleared; a second clr at cycle 10 extends the clear to 42 cycles.
REQ-043 With SHIFT_BUF_SYM_EN, write values 0..31 to ch1 and read tap 3 -> out=28, out_sym=3.
